// File: rtl/flow_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flow_pkg : opcodes, SR bit indices, FSM and decode types          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package flow_pkg;

   localparam logic [4:0] OP_TRAP     = 5'h00;
   localparam logic [4:0] OP_NOP      = 5'h01;
   localparam logic [4:0] OP_JMP      = 5'h02;
   localparam logic [4:0] OP_JZ       = 5'h03;
   localparam logic [4:0] OP_JS       = 5'h04;
   localparam logic [4:0] OP_JZS      = 5'h05;
   localparam logic [4:0] OP_LDSR     = 5'h06;
   localparam logic [4:0] OP_XSR      = 5'h07;
   localparam logic [4:0] OP_ALU_BASE = 5'h08;

   localparam int SR_Z = 0;
   localparam int SR_S = 1;
   localparam int SR_C = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_TRAP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      JC_ALWAYS = 2'd0,
      JC_ZERO   = 2'd1,
      JC_SIGN   = 2'd2,
      JC_ZS     = 2'd3
   } jump_cond_t;

   typedef struct packed {
      logic       is_alu;
      logic       is_jump;
      jump_cond_t jump_cond;
      logic       is_sr_op;
      logic       sr_xor;
      logic       is_trap;
   } decode_t;

   function automatic logic is_alu_op(input logic [4:0] op);
      return op >= OP_ALU_BASE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flow_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flow_decode : combinational opcode -> instruction class decode   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module flow_decode
   import flow_pkg::*;
(
   input  logic [4:0] opcode,
   output decode_t    dec
);

   always_comb begin
      dec           = '0;
      dec.jump_cond = JC_ALWAYS;
      dec.is_alu    = is_alu_op(opcode);
      dec.is_trap   = (opcode == OP_TRAP);
      case (opcode)
         OP_JMP:  dec.is_jump = 1'b1;
         OP_JZ:   begin dec.is_jump = 1'b1; dec.jump_cond = JC_ZERO; end
         OP_JS:   begin dec.is_jump = 1'b1; dec.jump_cond = JC_SIGN; end
         OP_JZS:  begin dec.is_jump = 1'b1; dec.jump_cond = JC_ZS;   end
         OP_LDSR: dec.is_sr_op = 1'b1;
         OP_XSR:  begin dec.is_sr_op = 1'b1; dec.sr_xor = 1'b1; end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/flow_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flow_sequencer : fetch/decode/issue sequencer with status reg    |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module flow_sequencer
   import flow_pkg::*;
#(
   parameter int               ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              trap_clr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [19:0]       imem_data,
   output logic              alu_valid,
   output logic [4:0]        alu_op,
   output logic              alu_mode,
   input  logic              alu_zero,
   input  logic              alu_sign,
   input  logic              alu_carry,
   output logic [2:0]        sr,
   output logic [ADDR_W-1:0] pc,
   output logic              retire,
   output logic              trap
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, target;
   logic [19:0]       ir_q, ir_d;
   logic [2:0]        sr_q, sr_d;
   logic              imem_req_q, imem_req_d;
   logic              alu_valid_q, alu_valid_d;
   logic              retire_q, retire_d;
   logic              trap_q, trap_d;
   logic              taken;
   decode_t           dec;
   logic              unused_ir;

   // Decoding ir_d lets the registered outputs for EXEC be computed while
   // the instruction word is still arriving; in EXEC ir_d equals ir_q.
   assign ir_d = (state_q == ST_FETCH && imem_valid) ? imem_data : ir_q;

   flow_decode u_decode (
      .opcode (ir_d[19:15]),
      .dec    (dec)
   );

   assign pc_inc    = pc_q + ADDR_W'(1);
   assign target    = ir_q[ADDR_W-1:0];
   assign unused_ir = ^ir_q;

   always_comb begin
      taken = 1'b1;
      case (dec.jump_cond)
         JC_ZERO: taken = sr_q[SR_Z];
         JC_SIGN: taken = sr_q[SR_S];
         JC_ZS:   taken = sr_q[SR_Z] | sr_q[SR_S];
         default: taken = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sr_d    = sr_q;
      case (state_q)
         ST_IDLE:  if (run) state_d = ST_FETCH;
         ST_FETCH: if (imem_valid) state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = run ? ST_FETCH : ST_IDLE;
            pc_d    = pc_inc;
            if (dec.is_trap) begin
               state_d = ST_TRAP;
               pc_d    = pc_q;
            end else if (dec.is_alu) begin
               sr_d = {alu_carry, alu_sign, alu_zero};
            end else if (dec.is_jump) begin
               if (taken) pc_d = target;
            end else if (dec.is_sr_op) begin
               sr_d = dec.sr_xor ? (sr_q ^ ir_q[2:0]) : ir_q[2:0];
            end
         end
         ST_TRAP: begin
            if (trap_clr) begin
               state_d = ST_IDLE;
               pc_d    = pc_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      imem_req_d  = (state_d == ST_FETCH);
      retire_d    = (state_d == ST_EXEC) && !dec.is_trap;
      alu_valid_d = (state_d == ST_EXEC) && dec.is_alu;
      trap_d      = (state_d == ST_TRAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         sr_q        <= '0;
         imem_req_q  <= 1'b0;
         alu_valid_q <= 1'b0;
         retire_q    <= 1'b0;
         trap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         sr_q        <= sr_d;
         imem_req_q  <= imem_req_d;
         alu_valid_q <= alu_valid_d;
         retire_q    <= retire_d;
         trap_q      <= trap_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign alu_valid = alu_valid_q;
   assign alu_op    = ir_q[19:15];
   assign alu_mode  = ir_q[14];
   assign sr        = sr_q;
   assign pc        = pc_q;
   assign retire    = retire_q;
   assign trap      = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_flow_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_flow_sequencer : scoreboard bench for flow_sequencer          |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
module tb_flow_sequencer;

   localparam logic [4:0] T_TRAP = 5'h00, T_NOP = 5'h01, T_JMP = 5'h02, T_JZ = 5'h03;
   localparam logic [4:0] T_JZS  = 5'h05, T_LDSR = 5'h06, T_XSR = 5'h07;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        trap_clr = 1'b0;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_valid = 1'b0;
   logic [19:0] imem_data = '0;
   logic        alu_valid;
   logic [4:0]  alu_op;
   logic        alu_mode;
   logic        alu_zero = 1'b0;
   logic        alu_sign = 1'b0;
   logic        alu_carry = 1'b0;
   logic [2:0]  sr;
   logic [9:0]  pc;
   logic        retire;
   logic        trap;

   typedef struct {
      logic       alu;
      logic [9:0] pc;
      logic [2:0] sr;
   } exp_t;

   exp_t        sb[$];
   logic [19:0] mem [0:1023];
   int          tests = 0;
   int          fails = 0;
   int          retire_cnt = 0;
   int          stall_cycles = 0;

   flow_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .trap_clr(trap_clr),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data),
      .alu_valid(alu_valid), .alu_op(alu_op), .alu_mode(alu_mode),
      .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_carry(alu_carry),
      .sr(sr), .pc(pc), .retire(retire), .trap(trap)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] ins(input logic [4:0] op, input logic mode,
                                       input logic [13:0] arg);
      return {op, mode, arg};
   endfunction

   // Instruction memory: answers a request after stall_cycles idle cycles
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1 && !rst) begin
            if (cnt < stall_cycles) begin
               imem_valid = 1'b0;
               cnt++;
            end else begin
               imem_valid = 1'b1;
               imem_data  = mem[imem_addr];
               cnt        = 0;
            end
         end else begin
            imem_valid = 1'b0;
            cnt        = 0;
         end
      end
   end

   // Retire monitor: pops one expectation per retire pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (retire === 1'b1 && !rst) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_retire: unexpected retire at pc=%h, expected none", pc);
            end else begin
               e = sb.pop_front();
               tests++;
               if (alu_valid !== e.alu) begin
                  fails++;
                  $display("FAIL sb_alu_valid: got %b expected %b", alu_valid, e.alu);
               end
               @(negedge clk);
               tests++;
               if (pc !== e.pc || sr !== e.sr) begin
                  fails++;
                  $display("FAIL sb_state: got pc=%h sr=%b expected pc=%h sr=%b",
                           pc, sr, e.pc, e.sr);
               end
               tests++;
               if (retire !== 1'b0 || alu_valid !== 1'b0) begin
                  fails++;
                  $display("FAIL sb_pulse: got retire=%b alu_valid=%b expected 0/0",
                           retire, alu_valid);
               end
            end
            retire_cnt++;
         end
      end
   end

   task automatic push(input logic alu, input logic [9:0] p, input logic [2:0] s);
      exp_t e;
      e.alu = alu; e.pc = p; e.sr = s;
      sb.push_back(e);
   endtask

   task automatic prep;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      stall_cycles = 0;
      trap_clr     = 1'b0;
      run          = 1'b0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      retire_cnt = 0;
   endtask

   task automatic wait_trap(input string name);
      int n;
      n = 0;
      while (trap !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (trap !== 1'b1) begin
         fails++;
         $display("FAIL %s_trap_timeout: got trap=%b expected 1", name, trap);
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s_sb_left: got %0d pending expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      run = 1'b1;
      @(negedge clk);
      tests++;
      if ({imem_req, alu_valid, retire, trap, sr, pc, imem_addr} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got req=%b av=%b ret=%b trap=%b sr=%b pc=%h addr=%h expected all 0",
                  imem_req, alu_valid, retire, trap, sr, pc, imem_addr);
      end
   endtask

   task automatic test_nop_latency;
      prep();
      mem[0] = ins(T_NOP, 1'b0, 14'h0);
      push(1'b0, 10'h001, 3'b000);
      run = 1'b1;
      @(negedge clk);
      tests++;
      if (retire !== 1'b0 || imem_req !== 1'b0) begin
         fails++;
         $display("FAIL lat_cycle1: got retire=%b req=%b expected 0/0", retire, imem_req);
      end
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
         fails++;
         $display("FAIL lat_cycle2: got req=%b addr=%h expected 1/000", imem_req, imem_addr);
      end
      @(negedge clk);
      tests++;
      if (retire !== 1'b1) begin
         fails++;
         $display("FAIL lat_cycle3: got retire=%b expected 1", retire);
      end
      wait_trap("nop");
   endtask

   task automatic test_ldsr_jz;
      prep();
      mem[0] = ins(T_LDSR, 1'b0, 14'h0001);
      mem[1] = ins(T_JZ,   1'b0, 14'h0155);
      push(1'b0, 10'h001, 3'b001);
      push(1'b0, 10'h155, 3'b001);
      run = 1'b1;
      wait_trap("ldsr_jz");
      tests++;
      if (pc !== 10'h155) begin
         fails++;
         $display("FAIL ldsr_jz_pc: got %h expected 155", pc);
      end
   endtask

   task automatic test_back_to_back;
      prep();
      mem[0] = ins(T_JMP, 1'b0, 14'h0005);
      mem[5] = ins(T_JZS, 1'b0, 14'h0020);
      mem[6] = ins(T_XSR, 1'b0, 14'h0002);
      mem[7] = ins(T_JZS, 1'b0, 14'h0020);
      push(1'b0, 10'h005, 3'b000);
      push(1'b0, 10'h006, 3'b000);
      push(1'b0, 10'h007, 3'b010);
      push(1'b0, 10'h020, 3'b010);
      run = 1'b1;
      wait_trap("jzs");
   endtask

   task automatic wait_retire_edge(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (retire !== 1'b1 && n < 100);
      tests++;
      if (retire !== 1'b1) begin
         fails++;
         $display("FAIL %s_timeout: got retire=%b expected 1", name, retire);
      end
   endtask

   task automatic test_alu;
      prep();
      mem[0] = ins(5'h0A, 1'b1, 14'h0123);
      mem[1] = ins(5'h1F, 1'b0, 14'h0000);
      push(1'b1, 10'h001, 3'b110);
      push(1'b1, 10'h002, 3'b001);
      alu_zero = 1'b0; alu_sign = 1'b1; alu_carry = 1'b1;
      run = 1'b1;
      wait_retire_edge("alu1");
      tests++;
      if (alu_op !== 5'h0A || alu_mode !== 1'b1) begin
         fails++;
         $display("FAIL alu1_fields: got op=%h mode=%b expected 0a/1", alu_op, alu_mode);
      end
      @(negedge clk);
      alu_zero = 1'b1; alu_sign = 1'b0; alu_carry = 1'b0;
      wait_retire_edge("alu2");
      tests++;
      if (alu_op !== 5'h1F || alu_mode !== 1'b0) begin
         fails++;
         $display("FAIL alu2_fields: got op=%h mode=%b expected 1f/0", alu_op, alu_mode);
      end
      wait_trap("alu");
   endtask

   task automatic test_wrap_trap;
      int n;
      prep();
      mem[0]     = ins(T_JMP, 1'b0, 14'h03FF);
      mem[10'h3FF] = ins(T_NOP, 1'b0, 14'h0);
      push(1'b0, 10'h3FF, 3'b000);
      push(1'b0, 10'h000, 3'b000);
      for (int i = 1; i <= 4; i++) push(1'b0, 10'(i), 3'b000);
      run = 1'b1;
      n = 0;
      while (retire_cnt < 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 4; i++) mem[i] = ins(T_NOP, 1'b0, 14'h0);
      wait_trap("wrap");
      run = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (trap !== 1'b1 || pc !== 10'h004 || retire_cnt != 6) begin
         fails++;
         $display("FAIL trap_hold: got trap=%b pc=%h retires=%0d expected 1/004/6",
                  trap, pc, retire_cnt);
      end
      trap_clr = 1'b1;
      @(negedge clk);
      trap_clr = 1'b0;
      @(negedge clk);
      tests++;
      if (trap !== 1'b0 || pc !== 10'h005 || imem_req !== 1'b0 || retire_cnt != 6) begin
         fails++;
         $display("FAIL trap_clr: got trap=%b pc=%h req=%b retires=%0d expected 0/005/0/6",
                  trap, pc, imem_req, retire_cnt);
      end
   endtask

   task automatic test_run_stop;
      prep();
      for (int i = 0; i < 8; i++) mem[i] = ins(T_NOP, 1'b0, 14'h0);
      stall_cycles = 3;
      push(1'b0, 10'h001, 3'b000);
      run = 1'b1;
      @(posedge clk);
      #1 run = 1'b0;
      repeat (12) @(negedge clk);
      tests++;
      if (imem_req !== 1'b0 || pc !== 10'h001 || retire_cnt != 1 || sb.size() != 0) begin
         fails++;
         $display("FAIL run_stop: got req=%b pc=%h retires=%0d expected 0/001/1",
                  imem_req, pc, retire_cnt);
      end
   endtask

   task automatic test_stall_reset;
      int  n;
      logic found;
      prep();
      mem[0] = ins(T_LDSR, 1'b0, 14'h0007);
      mem[1] = ins(T_JMP,  1'b0, 14'h02AB);
      stall_cycles = 7;
      push(1'b0, 10'h001, 3'b111);
      run = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         tests++;
         if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            fails++;
            $display("FAIL stall_%0d: got req=%b addr=%h expected 1/000", i, imem_req, imem_addr);
         end
      end
      found = 1'b0;
      n = 0;
      while (!found && n < 60) begin
         @(posedge clk);
         #1;
         if (retire === 1'b1 && pc === 10'h001) found = 1'b1;
         n++;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL jmp_exec_timeout: got pc=%h expected EXEC at 001", pc);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({imem_req, alu_valid, retire, trap, sr, pc, imem_addr} !== '0) begin
         fails++;
         $display("FAIL mid_reset: got req=%b av=%b ret=%b trap=%b sr=%b pc=%h expected all 0",
                  imem_req, alu_valid, retire, trap, sr, pc);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (sb.size() != 0 || pc !== 10'h000) begin
         fails++;
         $display("FAIL mid_reset_hold: got pending=%0d pc=%h expected 0/000", sb.size(), pc);
      end
   endtask

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nop_latency();
      test_ldsr_jz();
      test_back_to_back();
      test_alu();
      test_wrap_trap();
      test_run_stop();
      test_stall_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
